// File: rtl/final_image_writer.sv
// Final image writer: accepts a stream of pixels through a small skid FIFO and
// writes them to consecutive image memory addresses 0..IMG_SIZE-1, honouring
// backpressure from the memory side. One image per start, done pulses at the end.
module final_image_writer #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int IMG_SIZE   = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              pix_ready,
  input  logic              out_stall,
  output logic              WE,
  output logic [ADDR_W-1:0] wA,
  output logic [DATA_W-1:0] WD,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] IMG_CNT   = CNT_W'(IMG_SIZE);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    occ;
  logic [CNT_W-1:0]  acc_cnt;
  logic [CNT_W-1:0]  wr_cnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              clr;

  assign fifo_full  = (occ == DEPTH_CNT);
  assign fifo_empty = (occ == '0);
  assign push       = pix_valid & pix_ready;
  // Pop depends only on registered state and out_stall, so it never looks at push.
  assign pop        = ~fifo_empty & ~out_stall & ((state == RUN) | (state == DRAIN));
  assign clr        = (state == IDLE) & start;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and status outputs, all decoded from registered state
  always_comb begin
    state_nxt = state;
    pix_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy      = 1'b1;
        pix_ready = ~fifo_full & (acc_cnt < IMG_CNT);
        if (push && (acc_cnt == IMG_CNT - CNT_W'(1))) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if ((wr_cnt == IMG_CNT) && fifo_empty) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counters and FIFO pointers; cleared on reset and when a new image starts
  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      acc_cnt <= '0;
      wr_cnt  <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
    end else begin
      if (push) begin
        acc_cnt <= acc_cnt + CNT_W'(1);
        wr_ptr  <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        wr_cnt <= wr_cnt + CNT_W'(1);
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + (PTR_W + 1)'(1);
        2'b01:   occ <= occ - (PTR_W + 1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  // FIFO storage: data only, never reset
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= pix_data;
  end

  // Registered memory write port; address and data hold while WE is low
  always_ff @(posedge CLK) begin
    if (RST) begin
      WE <= 1'b0;
      wA <= '0;
      WD <= '0;
    end else begin
      WE <= pop;
      if (pop) begin
        wA <= wr_cnt[ADDR_W-1:0];
        WD <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_final_image_writer.sv
// Testbench for final_image_writer: two instances (IMG_SIZE=4/FIFO 2 and
// IMG_SIZE=8/FIFO 4 with a 3-bit address) share one directed stimulus stream.
module tb_final_image_writer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       start = 1'b0;
  logic       pix_valid = 1'b0;
  logic       out_stall = 1'b0;
  logic [7:0] pix_data = 8'h00;
  logic [1:0] rdy, we, busy, done;
  logic [7:0] wa0;
  logic [2:0] wa1;
  logic [7:0] wd0, wd1;

  always #5 CLK = ~CLK;

  final_image_writer #(.ADDR_W(8), .DATA_W(8), .IMG_SIZE(4), .FIFO_DEPTH(2)) dut0 (
    .CLK(CLK), .RST(RST), .start(start), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(rdy[0]), .out_stall(out_stall), .WE(we[0]), .wA(wa0), .WD(wd0),
    .busy(busy[0]), .done(done[0]));

  final_image_writer #(.ADDR_W(3), .DATA_W(8), .IMG_SIZE(8), .FIFO_DEPTH(4)) dut1 (
    .CLK(CLK), .RST(RST), .start(start), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(rdy[1]), .out_stall(out_stall), .WE(we[1]), .wA(wa1), .WD(wd1),
    .busy(busy[1]), .done(done[1]));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int img(int i);
    return (i == 0) ? 4 : 8;
  endfunction

  function automatic int depth(int i);
    return (i == 0) ? 2 : 4;
  endfunction

  // Behavioural model: phase 0 idle, 1 run, 2 drain, 3 done. The FIFO is the
  // slice of the acceptance log between the write count and the accept count.
  int m_ph[2];
  int m_acc[2];
  int m_wrc[2];
  int m_log[2][8];
  int m_we[2];
  int m_wa[2];
  int m_wd[2];

  // Observations of the DUTs for literal end-of-image checks
  int n_we[2];
  int n_done[2];
  int n_acc[2];
  int first_wa[2];
  int last_we_cyc[2];
  int done_cyc[2];
  int wd_at[2][8];
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge CLK) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      int occ;
      int wrc0;
      bit rdy_m;
      bit push;
      bit pop;
      if (chk_en && pix_valid && rdy[i]) n_acc[i]++;
      occ  = m_acc[i] - m_wrc[i];
      wrc0 = m_wrc[i];
      if (RST) begin
        m_ph[i]  = 0;
        m_acc[i] = 0;
        m_wrc[i] = 0;
        m_we[i]  = 0;
        m_wa[i]  = 0;
        m_wd[i]  = 0;
      end else begin
        rdy_m = (m_ph[i] == 1) && (occ < depth(i)) && (m_acc[i] < img(i));
        push  = pix_valid && rdy_m;
        pop   = (occ > 0) && !out_stall && (m_ph[i] == 1 || m_ph[i] == 2);
        m_we[i] = pop ? 1 : 0;
        if (pop) begin
          m_wa[i] = m_wrc[i];
          m_wd[i] = m_log[i][m_wrc[i]];
          m_wrc[i]++;
        end
        if (push) begin
          m_log[i][m_acc[i]] = int'(pix_data);
          m_acc[i]++;
        end
        case (m_ph[i])
          0: if (start) begin m_ph[i] = 1; m_acc[i] = 0; m_wrc[i] = 0; end
          1: if (m_acc[i] == img(i)) m_ph[i] = 2;
          2: if (wrc0 == img(i) && occ == 0) m_ph[i] = 3;
          default: m_ph[i] = 0;
        endcase
      end
    end
    #1;
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        int a_wa;
        int a_wd;
        int e_rdy;
        a_wa  = (i == 0) ? int'(wa0) : int'(wa1);
        a_wd  = (i == 0) ? int'(wd0) : int'(wd1);
        e_rdy = ((m_ph[i] == 1) && (m_acc[i] - m_wrc[i] < depth(i)) && (m_acc[i] < img(i))) ? 1 : 0;
        chk($sformatf("pix_ready[%0d] cyc %0d", i, cyc), int'(rdy[i]), e_rdy);
        chk($sformatf("busy[%0d] cyc %0d", i, cyc), int'(busy[i]), (m_ph[i] == 1 || m_ph[i] == 2) ? 1 : 0);
        chk($sformatf("done[%0d] cyc %0d", i, cyc), int'(done[i]), (m_ph[i] == 3) ? 1 : 0);
        chk($sformatf("WE[%0d] cyc %0d", i, cyc), int'(we[i]), m_we[i]);
        chk($sformatf("wA[%0d] cyc %0d", i, cyc), a_wa, m_wa[i]);
        chk($sformatf("WD[%0d] cyc %0d", i, cyc), a_wd, m_wd[i]);
        if (we[i]) begin
          if (n_we[i] == 0) first_wa[i] = a_wa;
          if (a_wa < 8) wd_at[i][a_wa] = a_wd;
          n_we[i]++;
          last_we_cyc[i] = cyc;
        end
        if (done[i]) begin
          n_done[i]++;
          done_cyc[i] = cyc;
        end
      end
    end
  end

  task automatic clr_rec();
    for (int i = 0; i < 2; i++) begin
      n_we[i] = 0;
      n_done[i] = 0;
      n_acc[i] = 0;
      first_wa[i] = -1;
      for (int k = 0; k < 8; k++) wd_at[i][k] = -1;
    end
  endtask

  // Advance one cycle; the next pixel value is 0x10 plus the pixels already taken
  task automatic step();
    @(negedge CLK);
    pix_data = 8'(32'h10 + m_acc[1]);
  endtask

  // One image on the 8-pixel instance with optional initial stall, bubbles and a stray start
  task automatic run_img(string tag, int stall_cyc, bit toggle, int start_mid, int ncyc);
    clr_rec();
    pix_data = 8'h10;
    start = 1'b1;
    step();
    start = 1'b0;
    pix_valid = 1'b1;
    out_stall = (stall_cyc > 0);
    for (int c = 0; c < ncyc; c++) begin
      if (c == stall_cyc) out_stall = 1'b0;
      if (toggle) pix_valid = (c % 2 == 0);
      start = (c == start_mid);
      step();
      if (out_stall) chk({tag, " WE while stalled"}, int'(we[1]), 0);
      if (out_stall && c >= 3) chk({tag, " ready while stalled"}, int'(rdy[1]), 0);
      if (c == stall_cyc - 1) chk({tag, " accepted during stall"}, n_acc[1], 4);
      if (c == 3 && !toggle) chk({tag, " ready0 after 4 accepts"}, int'(rdy[0]), 0);
    end
    pix_valid = 1'b0;
    start = 1'b0;
    step();
    step();
    chk({tag, " writes"}, n_we[1], 8);
    chk({tag, " accepts"}, n_acc[1], 8);
    chk({tag, " done pulses"}, n_done[1], 1);
    chk({tag, " first wA"}, first_wa[1], 0);
    for (int k = 0; k < 8; k++) chk($sformatf("%s WD at %0d", tag, k), wd_at[1][k], 8'h10 + k);
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    chk_en = 1'b1;
    chk("reset WE", int'(we[1]), 0);
    chk("reset wA", int'(wa1), 0);
    chk("reset WD", int'(wd1), 0);
    chk("reset busy", int'(busy[1]), 0);
    chk("reset ready", int'(rdy[1]), 0);
    chk("reset done", int'(done[0]), 0);
    RST = 1'b0;
    step();

    // Streaming
    run_img("stream", 0, 1'b0, -1, 14);
    chk("stream img4 writes", n_we[0], 4);
    chk("stream img4 done pulses", n_done[0], 1);
    chk("stream img4 done after last WE", done_cyc[0] - last_we_cyc[0], 1);
    chk("stream img4 WD at 0", wd_at[0][0], 8'h10);
    chk("stream img4 WD at 3", wd_at[0][3], 8'h13);
    chk("stream img8 done after last WE", done_cyc[1] - last_we_cyc[1], 1);

    // Backpressure, then full FIFO with simultaneous push and pop on release
    run_img("backpressure", 10, 1'b0, -1, 26);
    run_img("full release", 5, 1'b0, -1, 22);

    // Bubbles on pix_valid
    run_img("bubbles", 0, 1'b1, -1, 26);

    // Stray start while running
    run_img("ignored start", 0, 1'b0, 3, 16);

    // Reset after three writes, then a fresh image
    clr_rec();
    pix_data = 8'h10;
    start = 1'b1;
    step();
    start = 1'b0;
    pix_valid = 1'b1;
    begin
      int k;
      k = 0;
      while (n_we[1] < 3 && k < 20) begin
        step();
        k++;
      end
    end
    chk("reset-mid three writes seen", n_we[1], 3);
    RST = 1'b1;
    pix_valid = 1'b0;
    step();
    chk("reset-mid WE", int'(we[1]), 0);
    chk("reset-mid busy", int'(busy[1]), 0);
    chk("reset-mid wA", int'(wa1), 0);
    RST = 1'b0;
    step();
    run_img("after reset", 0, 1'b0, -1, 14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
    $fatal(1);
  end

endmodule
